// File: rtl/mod_ctrl.sv
// -----------------------------------------------------------------------------
// mod_ctrl
// Controller for the AM/FM modulator datapath.
//   - Paces source samples into the modulator at one sample every (div+1)
//     cycles while running.
//   - Keeps shadow copies of the modulator configuration. A commit drains the
//     modulator pipeline, copies shadow -> active, then pulses the datapath
//     reset so the DDS accumulator restarts from a clean state.
//
// Parameters
//   LAT      modulator input-to-output latency; drain gives up after 2*LAT cycles
//   RST_CYC  number of cycles dp_rst is held after a configuration is applied (>=1)
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   enable         1 = issue samples, 0 = drain then idle
//   cfg_we/addr/wdata  shadow register write (0 frec_por, 1 im_am, 2 im_fm,
//                      3 {mode[16], div[15:0]})
//   cfg_commit     apply shadow registers to the datapath
//   cfg_busy       commit in progress; writes and commits are ignored
//   s_data/s_valid/s_ready  sample source handshake
//   dp_*           modulator sample, valid, active config and reset
//   dp_val_out     modulator output valid (retires one in-flight sample)
//   underrun_cnt   saturating count of ticks with no sample available
//   drain_err      sticky: a drain timed out with samples still in flight
//   o_dbg_state    current FSM state (IDLE=0 RUN=1 DRAIN=2 APPLY=3 FLUSH=4)
//
// Handshake: a sample transfers on a cycle where s_valid and s_ready are both
// high. s_ready is a pure function of registered state (the pacing tick), so
// the source may sample it without a combinational path back from s_valid.
// -----------------------------------------------------------------------------
module mod_ctrl #(
    parameter int LAT     = 7,
    parameter int RST_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [23:0] cfg_wdata,
    input  logic        cfg_commit,
    output logic        cfg_busy,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] dp_data,
    output logic        dp_val_in,
    output logic        dp_c_fm_am,
    output logic [23:0] dp_frec_por,
    output logic [15:0] dp_im_am,
    output logic [15:0] dp_im_fm,
    output logic        dp_rst,
    input  logic        dp_val_out,
    output logic [15:0] underrun_cnt,
    output logic        drain_err,
    output logic [2:0]  o_dbg_state
);

    localparam int DRAIN_MAX = 2 * LAT;
    localparam int DW        = $clog2(DRAIN_MAX + 1);
    localparam int FW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_APPLY = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_busy;
    logic           r_pend;

    logic [23:0]    r_sh_frec;
    logic [15:0]    r_sh_am;
    logic [15:0]    r_sh_fm;
    logic           r_sh_mode;
    logic [15:0]    r_sh_div;

    logic [23:0]    r_act_frec;
    logic [15:0]    r_act_am;
    logic [15:0]    r_act_fm;
    logic           r_act_mode;
    logic [15:0]    r_act_div;

    logic [15:0]    r_tcnt;
    logic [15:0]    r_dp_data;
    logic           r_dp_val;
    logic [3:0]     r_infl;
    logic [DW-1:0]  r_dcnt;
    logic [FW-1:0]  r_fcnt;
    logic [15:0]    r_under;
    logic           r_derr;

    logic           w_commit;
    logic           w_we;
    logic           w_tick;
    logic           w_leave;
    logic           w_accept;
    logic           w_miss;
    logic           w_drain_to;
    logic           w_drain_done;
    logic           w_flush_last;
    logic           w_pend_any;

    // Commits and writes are only honoured while no commit is in progress.
    assign w_commit     = cfg_commit & ~r_busy;
    assign w_we         = cfg_we & ~r_busy;

    // Leaving RUN wins over a tick in the same cycle: the sample is not taken.
    assign w_leave      = (r_state == S_RUN) & (w_commit | ~enable);
    assign w_accept     = w_tick & s_valid & ~w_leave;
    assign w_miss       = w_tick & ~s_valid & ~w_leave;

    assign w_drain_to   = (r_state == S_DRAIN) && (r_dcnt == DW'(DRAIN_MAX - 1));
    assign w_drain_done = (r_infl == 4'd0) || w_drain_to;
    assign w_flush_last = (r_fcnt == FW'(RST_CYC - 1));

    // A commit seen in the very cycle the drain finishes still counts.
    assign w_pend_any   = r_pend | w_commit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    w_next = S_APPLY;
                end else if (enable) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_leave) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_next = w_pend_any ? S_APPLY : S_IDLE;
                end
            end
            S_APPLY: begin
                w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_next = enable ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_tick  = (r_state == S_RUN) && (r_tcnt == r_act_div);
        s_ready = w_tick;
        dp_rst  = rst | (r_state == S_FLUSH);
    end

    // ---------------- commit tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (w_commit) begin
                r_busy <= 1'b1;
            end else if (w_next == S_IDLE || w_next == S_RUN) begin
                r_busy <= 1'b0;
            end

            if (r_state == S_APPLY) begin
                r_pend <= 1'b0;
            end else if (w_commit) begin
                r_pend <= 1'b1;
            end
        end
    end

    // ---------------- shadow and active configuration ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_frec  <= '0;
            r_sh_am    <= '0;
            r_sh_fm    <= '0;
            r_sh_mode  <= 1'b0;
            r_sh_div   <= '0;
            r_act_frec <= '0;
            r_act_am   <= '0;
            r_act_fm   <= '0;
            r_act_mode <= 1'b0;
            r_act_div  <= '0;
        end else begin
            if (w_we) begin
                case (cfg_addr)
                    2'd0: r_sh_frec <= cfg_wdata;
                    2'd1: r_sh_am   <= cfg_wdata[15:0];
                    2'd2: r_sh_fm   <= cfg_wdata[15:0];
                    default: begin
                        r_sh_mode <= cfg_wdata[16];
                        r_sh_div  <= cfg_wdata[15:0];
                    end
                endcase
            end
            // The pipeline is empty here, so the modulator never sees a
            // configuration change under a sample.
            if (r_state == S_APPLY) begin
                r_act_frec <= r_sh_frec;
                r_act_am   <= r_sh_am;
                r_act_fm   <= r_sh_fm;
                r_act_mode <= r_sh_mode;
                r_act_div  <= r_sh_div;
            end
        end
    end

    // ---------------- sample pacing ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_dp_data <= '0;
            r_dp_val  <= 1'b0;
            r_under   <= '0;
        end else begin
            // Held at zero outside RUN so every entry to RUN restarts the period.
            if (r_state != S_RUN || w_tick) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 16'd1;
            end

            r_dp_val <= w_accept;
            if (w_accept) begin
                r_dp_data <= s_data;
            end

            if (w_miss && r_under != 16'hFFFF) begin
                r_under <= r_under + 16'd1;
            end
        end
    end

    // ---------------- in-flight tracking and drain ----------------
    always_ff @(posedge clk) begin
        if (rst || r_state == S_FLUSH) begin
            r_infl <= '0;
        end else begin
            case ({r_dp_val, dp_val_out})
                2'b10: if (r_infl != 4'hF) r_infl <= r_infl + 4'd1;
                2'b01: if (r_infl != 4'h0) r_infl <= r_infl - 4'd1;
                default: r_infl <= r_infl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcnt <= '0;
            r_fcnt <= '0;
            r_derr <= 1'b0;
        end else begin
            r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + DW'(1) : '0;
            r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + FW'(1) : '0;
            // Only a timeout with samples still outstanding is an error.
            if (w_drain_to && r_infl != 4'd0) begin
                r_derr <= 1'b1;
            end
        end
    end

    assign cfg_busy     = r_busy;
    assign dp_data      = r_dp_data;
    assign dp_val_in    = r_dp_val;
    assign dp_c_fm_am   = r_act_mode;
    assign dp_frec_por  = r_act_frec;
    assign dp_im_am     = r_act_am;
    assign dp_im_fm     = r_act_fm;
    assign underrun_cnt = r_under;
    assign drain_err    = r_derr;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_ctrl
// Directed sequence with randomized sample data / valid patterns. Expected
// behaviour comes from timing arithmetic (tick index, drain length from the
// last issued sample), a sample queue and a model of shadow/active config.
// The modulator is modelled as a LAT-cycle echo of dp_val_in that can be muted.
// -----------------------------------------------------------------------------
module tb_mod_ctrl;

    localparam int LAT       = 7;
    localparam int RST_CYC   = 2;
    localparam int DRAIN_MAX = 2 * LAT;

    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_RUN   = 32'd1;
    localparam logic [31:0] ST_DRAIN = 32'd2;
    localparam logic [31:0] ST_APPLY = 32'd3;
    localparam logic [31:0] ST_FLUSH = 32'd4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        enable;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic        cfg_commit;
    logic        cfg_busy;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] dp_data;
    logic        dp_val_in;
    logic        dp_c_fm_am;
    logic [23:0] dp_frec_por;
    logic [15:0] dp_im_am;
    logic [15:0] dp_im_fm;
    logic        dp_rst;
    logic        dp_val_out;
    logic [15:0] underrun_cnt;
    logic        drain_err;
    logic [2:0]  o_dbg_state;

    mod_ctrl #(.LAT(LAT), .RST_CYC(RST_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_commit   (cfg_commit),
        .cfg_busy     (cfg_busy),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dp_data      (dp_data),
        .dp_val_in    (dp_val_in),
        .dp_c_fm_am   (dp_c_fm_am),
        .dp_frec_por  (dp_frec_por),
        .dp_im_am     (dp_im_am),
        .dp_im_fm     (dp_im_fm),
        .dp_rst       (dp_rst),
        .dp_val_out   (dp_val_out),
        .underrun_cnt (underrun_cnt),
        .drain_err    (drain_err),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- modulator model: LAT-cycle echo ----------------
    logic [LAT-1:0] echo_pipe;
    logic           echo_en;
    always @(posedge clk) begin
        if (dp_rst) echo_pipe <= '0;
        else        echo_pipe <= {echo_pipe[LAT-2:0], dp_val_in};
    end
    assign dp_val_out = echo_en & echo_pipe[LAT-1];

    // ---------------- scoreboard / model state ----------------
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_q[$];
    int          b_k;
    int          b_div;
    bit          prev_acc;
    int          last_issue;
    int          exp_under;
    int          under0;
    int          c_cyc;
    int          d_len;

    logic [23:0] sh_frec, act_frec;
    logic [15:0] sh_am, act_am, sh_fm, act_fm, sh_div, act_div;
    logic        sh_mode, act_mode;

    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [23:0] d);
        case (a)
            2'd0: sh_frec = d;
            2'd1: sh_am   = d[15:0];
            2'd2: sh_fm   = d[15:0];
            default: begin
                sh_mode = d[16];
                sh_div  = d[15:0];
            end
        endcase
    endtask

    task automatic model_apply();
        act_frec = sh_frec;
        act_am   = sh_am;
        act_fm   = sh_fm;
        act_mode = sh_mode;
        act_div  = sh_div;
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_frec"}, 32'(dp_frec_por), 32'(act_frec));
        chk({tag, "_im_am"}, 32'(dp_im_am), 32'(act_am));
        chk({tag, "_im_fm"}, 32'(dp_im_fm), 32'(act_fm));
        chk({tag, "_mode"}, 32'(dp_c_fm_am), 32'(act_mode));
    endtask

    // Write while no commit is in progress (IDLE).
    task automatic idle_write(input logic [1:0] a, input logic [23:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        model_write(a, d);
        tick_clk();
        cfg_we = 1'b0;
    endtask

    // Cycles after the last issued sample until the drain can finish, capped.
    function automatic int drain_len(input int c);
        int x;
        x = last_issue + LAT + 1;
        if (x < c + 1) x = c + 1;
        return (x - c > DRAIN_MAX) ? DRAIN_MAX : x - c;
    endfunction

    // One RUN cycle: check this cycle, then drive inputs for the coming edge.
    task automatic run_cycle(input bit vld, input bit leave_commit, input bit leave_dis,
                             input bit we, input logic [1:0] addr, input logic [23:0] wdata);
        bit tk;
        bit leave;
        tk    = ((b_k % (b_div + 1)) == 0);
        leave = leave_commit | leave_dis;
        chk("run_state", 32'(o_dbg_state), ST_RUN);
        chk("s_ready", 32'(s_ready), 32'(tk));
        chk("dp_val_in", 32'(dp_val_in), 32'(prev_acc));
        if (prev_acc) begin
            chk("dp_data", 32'(dp_data), 32'(exp_q.pop_front()));
            last_issue = cyc;
        end
        s_valid    = vld;
        s_data     = 16'($urandom);
        cfg_commit = leave_commit;
        enable     = ~leave_dis;
        cfg_we     = we;
        cfg_addr   = addr;
        cfg_wdata  = wdata;
        if (we) model_write(addr, wdata);
        prev_acc = tk && vld && !leave;
        if (prev_acc) exp_q.push_back(s_data);
        if (tk && !vld && !leave && exp_under != 65535) exp_under++;
        tick_clk();
        cfg_commit = 1'b0;
        cfg_we     = 1'b0;
        s_valid    = 1'b0;
        b_k++;
    endtask

    // DRAIN (d cycles) -> APPLY -> FLUSH -> RUN/IDLE. Optional write/commit in
    // the first DRAIN cycle; the write lands only if no commit is in progress.
    task automatic drain_seq(input int d, input bit from_commit, input bit cm1,
                             input bit we1, input logic [1:0] addr1, input logic [23:0] wdata1,
                             input bit exp_err);
        for (int i = 0; i < d; i++) begin
            chk("drain_state", 32'(o_dbg_state), ST_DRAIN);
            chk("drain_val_in", 32'(dp_val_in), 32'd0);
            chk("drain_s_ready", 32'(s_ready), 32'd0);
            chk("drain_busy", 32'(cfg_busy), 32'(from_commit || (cm1 && i > 0)));
            chk_cfg("drain_cfg");
            if (i == 0) begin
                cfg_commit = cm1; cfg_we = we1; cfg_addr = addr1; cfg_wdata = wdata1;
                if (we1 && !from_commit) model_write(addr1, wdata1);
            end
            tick_clk();
            cfg_commit = 1'b0;
            cfg_we     = 1'b0;
        end
        chk("apply_state", 32'(o_dbg_state), ST_APPLY);
        chk("apply_busy", 32'(cfg_busy), 32'd1);
        chk("apply_dp_rst", 32'(dp_rst), 32'd0);
        chk("drain_err", 32'(drain_err), 32'(exp_err));
        chk_cfg("apply_cfg_old");
        model_apply();
        tick_clk();
        for (int i = 0; i < RST_CYC; i++) begin
            chk("flush_state", 32'(o_dbg_state), ST_FLUSH);
            chk("flush_dp_rst", 32'(dp_rst), 32'd1);
            chk("flush_busy", 32'(cfg_busy), 32'd1);
            chk("flush_val_in", 32'(dp_val_in), 32'd0);
            chk_cfg("flush_cfg_new");
            tick_clk();
        end
        chk("post_state", 32'(o_dbg_state), enable ? ST_RUN : ST_IDLE);
        chk("post_busy", 32'(cfg_busy), 32'd0);
        chk("post_dp_rst", 32'(dp_rst), 32'd0);
        b_k      = 1;
        b_div    = int'(act_div);
        prev_acc = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_commit = 1'b0; s_data = '0; s_valid = 1'b0; echo_en = 1'b1;
        sh_frec = '0; sh_am = '0; sh_fm = '0; sh_div = '0; sh_mode = 1'b0;
        model_apply();
        last_issue = -100; exp_under = 0; prev_acc = 1'b0; b_k = 1; b_div = 0;

        // Reset defaults: dp_rst follows rst, everything else clears.
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            chk("rst_dp_rst", 32'(dp_rst), 32'd1);
        end
        rst = 1'b0;
        tick_clk();
        chk("rst_state", 32'(o_dbg_state), ST_IDLE);
        chk("rst_dp_rst_low", 32'(dp_rst), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_val_in", 32'(dp_val_in), 32'd0);
        chk("rst_dp_data", 32'(dp_data), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_drain_err", 32'(drain_err), 32'd0);
        chk_cfg("rst_cfg");

        // Commit from IDLE; div write shares the commit cycle (write lands first).
        idle_write(2'd0, 24'h0ABCDE);
        idle_write(2'd1, 24'h001234);
        idle_write(2'd2, 24'h000777);
        chk_cfg("idle_unapplied");
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 24'h000003; cfg_commit = 1'b1;
        model_write(2'd3, 24'h000003);
        tick_clk();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("idle_apply_state", 32'(o_dbg_state), ST_APPLY);
        chk("idle_apply_busy", 32'(cfg_busy), 32'd1);
        chk_cfg("idle_apply_old");
        model_apply();
        tick_clk();
        for (int i = 0; i < RST_CYC; i++) begin
            chk("idle_flush_dp_rst", 32'(dp_rst), 32'd1);
            chk("idle_flush_busy", 32'(cfg_busy), 32'd1);
            chk_cfg("idle_flush_new");
            tick_clk();
        end
        chk("idle_back_state", 32'(o_dbg_state), ST_IDLE);
        chk("idle_back_busy", 32'(cfg_busy), 32'd0);
        chk("idle_frec_const", 32'(dp_frec_por), 32'h0ABCDE);

        // Pacing with div = 3: valid held high, then random valid.
        enable = 1'b1;
        tick_clk();
        b_k = 1; b_div = int'(act_div); prev_acc = 1'b0;
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        for (int i = 0; i < 20; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        chk("underrun_random", 32'(underrun_cnt), 32'(exp_under));

        // Commit from RUN: new frec/mode/div written while running.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 24'h100000);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 24'h010001);
        for (int i = 0; i < int'($urandom_range(0, 5)); i++)
            run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        c_cyc = cyc;
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 24'd0);
        d_len = drain_len(c_cyc);
        // Busy protection: im_am write during the commit drain is dropped.
        drain_seq(d_len, 1'b1, 1'b0, 1'b1, 2'd1, 24'h00BEEF, 1'b0);
        chk("busy_protect_im_am", 32'(dp_im_am), 32'h1234);
        chk("commit_frec_const", 32'(dp_frec_por), 32'h100000);
        chk("commit_mode_const", 32'(dp_c_fm_am), 32'd1);

        // Underrun with div = 1: 10 cycles without valid -> 5 misses.
        under0 = exp_under;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        chk("underrun_delta", 32'(underrun_cnt), 32'(under0 + 5));
        chk("underrun_total", 32'(underrun_cnt), 32'(exp_under));

        // Drain timeout: modulator never answers.
        echo_en = 1'b0;
        chk("drain_err_before", 32'(drain_err), 32'd0);
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 24'd0);
        drain_seq(DRAIN_MAX, 1'b1, 1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
        echo_en = 1'b1;

        // Enable-initiated drain with a commit (and same-cycle write) in DRAIN.
        for (int i = 0; i < 8; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 2'd0, 24'd0);
        c_cyc = cyc;
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 24'd0);
        d_len = drain_len(c_cyc);
        drain_seq(d_len, 1'b0, 1'b1, 1'b1, 2'd2, 24'h005A5A, 1'b1);
        chk("latched_commit_im_fm", 32'(dp_im_fm), 32'h5A5A);

        tick_clk();
        chk("final_state", 32'(o_dbg_state), ST_IDLE);
        chk("final_val_in", 32'(dp_val_in), 32'd0);
        chk("final_underrun", 32'(underrun_cnt), 32'(exp_under));
        chk("final_drain_err", 32'(drain_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_ctrl.md
# mod_ctrl

Controller for the AM/FM modulator datapath. It paces input samples into the modulator at a programmable sample rate using a valid/ready handshake from the sample source. It holds shadow copies of the modulator configuration (carrier phase increment, AM index, FM index, mode, rate divider). Configuration changes are applied only after the modulator pipeline has drained, followed by a datapath reset so the DDS accumulator restarts cleanly.

## Interface
- LAT, 7, modulator input-to-output latency in cycles; sets the drain timeout to 2*LAT.
- RST_CYC, 2, number of cycles dp_rst is held in FLUSH; must be ≥1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = issue samples; 0 = drain, then idle.
- cfg_we  in  1  write strobe into the shadow register selected by cfg_addr.
- cfg_addr  in  2  0: frec_por[23:0]; 1: im_am[15:0]; 2: im_fm[15:0]; 3: {mode[16], div[15:0]}.
- cfg_wdata  in  24  write data; unused upper bits are ignored.
- cfg_commit  in  1  pulse to apply the shadow registers to the datapath.
- cfg_busy  out  1  commit in progress; writes and commits are ignored while high.
- s_data  in  16  signed input sample.
- s_valid  in  1  source has a sample.
- s_ready  out  1  sample accepted this cycle (when s_valid=1).
- dp_data  out  16  signed sample to the modulator.
- dp_val_in  out  1  sample valid to the modulator.
- dp_c_fm_am  out  1  mode to the modulator: 1 = FM, 0 = AM.
- dp_frec_por  out  24  active carrier phase increment.
- dp_im_am, dp_im_fm  out  16 each  active modulation indices.
- dp_rst  out  1  modulator reset.
- dp_val_out  in  1  modulator output valid.
- underrun_cnt  out  16  count of ticks with no sample available; saturates.
- drain_err  out  1  sticky flag: a drain timed out.

## Operation
- States: IDLE, RUN, DRAIN, APPLY, FLUSH.
- Reset: state IDLE. All shadow and active config = 0. All outputs = 0, except dp_rst = 1 while rst = 1 (dp_rst = rst | in FLUSH).
- Shadow writes: accepted on cfg_we when cfg_busy = 0. cfg_we and cfg_commit in the same cycle: the write lands first, and the commit uses the new value.
- **IDLE:**
  - On commit: go to APPLY, then FLUSH, then back to IDLE. cfg_busy is high from the cycle after the commit through the last FLUSH cycle.
  - If enable = 1 and no commit: go to RUN, and clear the tick counter.
- **RUN:**
  - A tick counter counts 0..div and wraps; tick = (cnt == div). div = 0 gives a tick every cycle.
  - s_ready = tick & (state == RUN). This is combinational from registered state only.
  - On tick with s_valid: dp_data ← s_data and dp_val_in ← 1, both registered, for one cycle.
  - On tick without s_valid: dp_val_in = 0, dp_data holds, underrun_cnt += 1 (saturates at 0xFFFF).
  - On commit, or on enable = 0: go to DRAIN. The commit or enable event takes priority over a tick in the same cycle; no sample is accepted.
- In-flight counter (4 bits):
  - +1 on dp_val_in, −1 on dp_val_out; both in the same cycle = no change.
  - Cleared by rst and in FLUSH.
- **DRAIN:**
  - dp_val_in = 0 and s_ready = 0.
  - Exit when in_flight == 0, or after 2*LAT cycles in DRAIN. On timeout, set drain_err (cleared only by rst).
  - Destination: APPLY if a commit is pending; otherwise IDLE.
  - A commit that arrives during an enable-initiated drain is latched and honoured.
- **APPLY (1 cycle):** copy shadow → active registers (dp_frec_por, dp_im_am, dp_im_fm, dp_c_fm_am, div).
- **FLUSH:** dp_rst = 1 for RST_CYC cycles. Then go to RUN if enable = 1, else IDLE. The tick counter is cleared on entry to RUN.
- rst asserted in any state: return to IDLE the next cycle. Pending commits are discarded.

## Timing
- Sample acceptance: s_ready on tick cycle T → dp_val_in and dp_data valid at T+1.
- First tick is on the (div+1)th cycle of RUN. The period is then div+1 cycles.
- Commit from RUN, drain completing in D cycles:
  - APPLY at cycle C+1+D.
  - dp_rst high for cycles C+2+D .. C+1+D+RST_CYC.
  - First RUN cycle at C+2+D+RST_CYC.
- Commit in IDLE: APPLY at C+1; active config is visible from C+2.
- dp_* configuration outputs change only on the APPLY edge. They are never updated while samples are in flight.
- cfg_busy is registered. It rises the cycle after the accepted commit and falls on entry to RUN or IDLE.

## Test plan
- **Reset defaults.** Hold rst for 3 cycles → dp_rst = 1 throughout. After release, all other outputs = 0 and state is IDLE.
- **Pacing.** div = 3, enable = 1, s_valid held high → s_ready on every 4th cycle, the first on the 4th RUN cycle. dp_val_in follows 1 cycle later, with dp_data equal to the accepted s_data.
- **Underrun.** div = 1, s_valid = 0 for 10 cycles in RUN → underrun_cnt = 5 and dp_val_in stays 0.
- **Commit from RUN.** Modulator model echoes dp_val_in delayed by 7 cycles. Write mode = 1 and frec_por = 0x100000, then commit → dp_val_in stops. APPLY happens once in_flight = 0, then dp_rst is high for 2 cycles. The new dp_frec_por and dp_c_fm_am = 1 appear before resumption, and cfg_busy spans the whole sequence.
- **Drain timeout.** Model never asserts dp_val_out, commit in RUN → DRAIN lasts exactly 14 cycles, drain_err = 1, and APPLY still occurs.
- **Busy protection.** cfg_we to addr 1 with 0xBEEF during DRAIN → ignored; dp_im_am keeps its previous value after the commit completes.
